// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings,
// sequencer state codes, default latencies and a small op-class helper.
package mdu_ctrl_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MFHI  = 3'd4,
        MDU_MFLO  = 3'd5,
        MDU_MTHI  = 3'd6,
        MDU_MTLO  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W           = 4;

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    // Latency loads are clamped into the representable 1..15 window.
    function automatic logic [CNT_W-1:0] clamp_cycles(input int n);
        if (n < 1) begin
            return CNT_W'(1);
        end else if (n > 15) begin
            return CNT_W'(15);
        end else begin
            return CNT_W'(n);
        end
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath for mult/multu/div/divu: produces the HI/LO pair
// and a divide-by-zero flag from the forwarded operands.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div0
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        signed_div;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] dividend;
    logic [31:0] divisor_mag;
    logic [31:0] divisor;
    logic [31:0] quot_mag;
    logic [31:0] rem_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // Low 64 bits of the sign-extended product equal the signed product.
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide runs on magnitudes; 0x80000000 negates to itself, which
    // is exactly 2^31 as an unsigned magnitude, so the overflow case is exact.
    assign signed_div  = (op == MDU_DIV);
    assign a_neg       = signed_div & A[31];
    assign b_neg       = signed_div & B[31];
    assign dividend    = a_neg ? (~A + 32'd1) : A;
    assign divisor_mag = b_neg ? (~B + 32'd1) : B;
    assign divisor     = (B == 32'd0) ? 32'd1 : divisor_mag;
    assign quot_mag    = dividend / divisor;
    assign rem_mag     = dividend % divisor;
    assign quot        = (a_neg ^ b_neg) ? (~quot_mag + 32'd1) : quot_mag;
    assign rem         = a_neg ? (~rem_mag + 32'd1) : rem_mag;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        div0   = 1'b0;
        case (op)
            MDU_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MDU_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            MDU_DIV, MDU_DIVU: begin
                res_hi = rem;
                res_lo = quot;
                div0   = (B == 32'd0);
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
                div0   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide sequencer: fixed-latency busy counter, HI/LO
// ownership, mfhi/mflo read mux and the D-stage HI/LO hazard stall.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  MDUOp,
    input  logic        start,
    input  logic        mt_en,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        req,
    input  logic        D_mdu_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] out,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [CNT_W-1:0] MULT_LOAD = clamp_cycles(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = clamp_cycles(DIV_CYCLES);

    mdu_state_e       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [31:0]      temp_hi_reg;
    logic [31:0]      temp_lo_reg;
    logic             temp_div0_reg;
    logic [31:0]      hi_reg;
    logic [31:0]      lo_reg;
    logic             busy_reg;

    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             res_div0;

    mdu_arith u_arith (
        .op     (MDUOp),
        .A      (A),
        .B      (B),
        .res_hi (res_hi),
        .res_lo (res_lo),
        .div0   (res_div0)
    );

    // Result is captured at the start edge and only committed when the
    // count expires, so a flush arriving mid-operation cannot touch HI/LO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= MDU_IDLE;
            cnt_reg       <= '0;
            temp_hi_reg   <= 32'd0;
            temp_lo_reg   <= 32'd0;
            temp_div0_reg <= 1'b0;
            hi_reg        <= 32'd0;
            lo_reg        <= 32'd0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                MDU_IDLE: begin
                    if (start && !req) begin
                        temp_hi_reg   <= res_hi;
                        temp_lo_reg   <= res_lo;
                        temp_div0_reg <= res_div0;
                        cnt_reg       <= is_div_op(MDUOp) ? DIV_LOAD : MULT_LOAD;
                        state_reg     <= MDU_BUSY;
                        busy_reg      <= 1'b1;
                    end else if (mt_en && !req) begin
                        if (MDUOp == MDU_MTHI) begin
                            hi_reg <= A;
                        end else if (MDUOp == MDU_MTLO) begin
                            lo_reg <= A;
                        end
                    end
                end
                MDU_BUSY: begin
                    if (cnt_reg == CNT_W'(1)) begin
                        // Divide by zero leaves the architectural HI/LO untouched.
                        if (!temp_div0_reg) begin
                            hi_reg <= temp_hi_reg;
                            lo_reg <= temp_lo_reg;
                        end
                        cnt_reg   <= '0;
                        state_reg <= MDU_IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= MDU_IDLE;
                    cnt_reg   <= '0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // start is included so an md/mf right behind a starting op stalls at once.
    assign stall = D_mdu_use & (start | busy_reg);

    always_comb begin
        out = 32'd0;
        if (MDUOp == MDU_MFHI) begin
            out = hi_reg;
        end else if (MDUOp == MDU_MFLO) begin
            out = lo_reg;
        end
    end

    assign busy = busy_reg;
    assign HI   = hi_reg;
    assign LO   = lo_reg;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed scenarios plus randomized ops,
// all compared against a cycle-numbered behavioural model of HI/LO and busy.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  MDUOp;
    logic        start;
    logic        mt_en;
    logic [31:0] A;
    logic [31:0] B;
    logic        req;
    logic        D_mdu_use;
    logic        busy;
    logic        stall;
    logic [31:0] out;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks = 0;
    int n_errors = 0;

    // Model: committed HI/LO, pending result, and the cycle number at which
    // the in-flight operation completes (busy while cyc < done).
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] p_hi = 32'd0;
    logic [31:0] p_lo = 32'd0;
    bit          p_dz = 1'b0;
    int          cyc  = 0;
    int          done = 0;

    mdu_ctrl dut (
        .clk       (clk),
        .reset     (rst_n),
        .MDUOp     (MDUOp),
        .start     (start),
        .mt_en     (mt_en),
        .A         (A),
        .B         (B),
        .req       (req),
        .D_mdu_use (D_mdu_use),
        .busy      (busy),
        .stall     (stall),
        .out       (out),
        .HI        (HI),
        .LO        (LO)
    );

    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic ref_op(input int op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] rh, output logic [31:0] rl, output bit dz);
        longint          sa;
        longint          sb;
        longint          sp;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        rh = 32'd0;
        rl = 32'd0;
        dz = 1'b0;
        case (op)
            0: begin
                sp = sa * sb;
                rh = sp[63:32];
                rl = sp[31:0];
            end
            1: begin
                up = ua * ub;
                rh = up[63:32];
                rl = up[31:0];
            end
            2: begin
                if (b == 32'd0) begin
                    dz = 1'b1;
                end else begin
                    sp = sa / sb;
                    rl = sp[31:0];
                    sp = sa % sb;
                    rh = sp[31:0];
                end
            end
            default: begin
                if (b == 32'd0) begin
                    dz = 1'b1;
                end else begin
                    up = ua / ub;
                    rl = up[31:0];
                    up = ua % ub;
                    rh = up[31:0];
                end
            end
        endcase
    endtask

    task automatic model_edge(input int op, input logic [31:0] a, input logic [31:0] b, input bit rq);
        bit was_busy;
        was_busy = (cyc < done);
        cyc++;
        if (was_busy) begin
            if (cyc == done && !p_dz) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (!rq) begin
            if (op < 4) begin
                ref_op(op, a, b, p_hi, p_lo, p_dz);
                done = cyc + ((op >= 2) ? 10 : 5);
            end else if (op == 6) begin
                m_hi = a;
            end else if (op == 7) begin
                m_lo = a;
            end
        end
    endtask

    // One clock: drive at the falling edge, check just after, step the model
    // on the rising edge.
    task automatic drive_cycle(input int op, input logic [31:0] a, input logic [31:0] b,
                               input bit rq, input bit du);
        bit          exp_busy;
        logic [31:0] exp_out;
        @(negedge clk);
        MDUOp     = op[2:0];
        start     = (op < 4);
        mt_en     = (op >= 6);
        A         = a;
        B         = b;
        req       = rq;
        D_mdu_use = du;
        #1;
        exp_busy = (cyc < done);
        exp_out  = (op == 4) ? m_hi : ((op == 5) ? m_lo : 32'd0);
        check32("busy", {31'd0, busy}, {31'd0, exp_busy});
        check32("stall", {31'd0, stall}, {31'd0, du & ((op < 4) | exp_busy)});
        check32("hi", HI, m_hi);
        check32("lo", LO, m_lo);
        check32("out", out, exp_out);
        if (op < 4 || op >= 6) begin
            $display("op=%0d A=%h B=%h req=%0d busy=%0d HI=%h LO=%h", op, a, b, rq, busy, HI, LO);
        end
        @(posedge clk);
        model_edge(op, a, b, rq);
    endtask

    task automatic idle(input int n, input bit du);
        for (int i = 0; i < n; i++) begin
            drive_cycle(5, 32'd0, 32'd0, 1'b0, du);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        MDUOp     = 3'd4;
        start     = 1'b0;
        mt_en     = 1'b0;
        A         = 32'd0;
        B         = 32'd0;
        req       = 1'b0;
        D_mdu_use = 1'b0;
        #12;
        check32("rst_busy", {31'd0, busy}, 32'd0);
        check32("rst_hi", HI, 32'd0);
        check32("rst_lo", LO, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // mult -2 * 3 with an md/mf instruction waiting in D throughout
        drive_cycle(0, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b1);
        idle(5, 1'b1);
        #1;
        check32("plan_mult_hi", HI, 32'hFFFF_FFFF);
        check32("plan_mult_lo", LO, 32'hFFFF_FFFA);
        idle(1, 1'b1);

        drive_cycle(3, 32'd7, 32'd2, 1'b0, 1'b0);
        idle(10, 1'b0);
        #1;
        check32("plan_divu_lo", LO, 32'd3);
        check32("plan_divu_hi", HI, 32'd1);

        drive_cycle(2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        idle(10, 1'b0);
        #1;
        check32("plan_div_lo", LO, 32'hFFFF_FFFD);
        check32("plan_div_hi", HI, 32'hFFFF_FFFF);

        drive_cycle(2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        idle(10, 1'b0);
        #1;
        check32("ovf_div_lo", LO, 32'h8000_0000);
        check32("ovf_div_hi", HI, 32'd0);

        drive_cycle(7, 32'h1234, 32'd0, 1'b0, 1'b0);
        drive_cycle(6, 32'h5678, 32'd0, 1'b0, 1'b0);
        drive_cycle(2, 32'd99, 32'd0, 1'b0, 1'b0);
        idle(10, 1'b0);
        #1;
        check32("div0_lo", LO, 32'h1234);
        check32("div0_hi", HI, 32'h5678);

        drive_cycle(0, 32'd5, 32'd6, 1'b1, 1'b0);
        #1;
        check32("req_mult_busy", {31'd0, busy}, 32'd0);
        drive_cycle(7, 32'hAA, 32'd0, 1'b1, 1'b0);
        #1;
        check32("req_mtlo_lo", LO, 32'h1234);

        // Asynchronous reset in the third busy cycle of a mult
        drive_cycle(0, 32'd3, 32'd4, 1'b0, 1'b0);
        idle(2, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check32("async_rst_busy", {31'd0, busy}, 32'd0);
        check32("async_rst_hi", HI, 32'd0);
        check32("async_rst_lo", LO, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        done = cyc;
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        idle(5, 1'b0);
        #1;
        check32("post_rst_hi", HI, 32'd1);
        check32("post_rst_lo", LO, 32'hFFFF_FFFE);

        for (int i = 0; i < 600; i++) begin
            int          op;
            int          sel;
            logic [31:0] a;
            logic [31:0] b;
            op  = $urandom_range(0, 7);
            sel = $urandom_range(0, 9);
            a   = (sel == 9) ? 32'h8000_0000 : $urandom;
            sel = $urandom_range(0, 9);
            b   = (sel == 0) ? 32'd0 : ((sel == 1) ? 32'hFFFF_FFFF : $urandom);
            if (op < 4 && $urandom_range(0, 2) != 0) begin
                op = 4 + $urandom_range(0, 1);
            end
            drive_cycle(op, a, b, ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1);
        end
        idle(12, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Sequences the E-stage multiply/divide unit: accepts mult/multu/div/divu/mthi/mtlo, models fixed multi-cycle latency with a busy counter, owns the HI/LO registers, and serves mfhi/mflo reads.
- Generates the D-stage stall when a HI/LO-using instruction is behind an active or starting operation.
- Honours the CP0 exception/interrupt request so a flushed E-stage instruction never changes HI/LO.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu after the start cycle (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu after the start cycle (legal range 1..15).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- MDUOp  input  3  E-stage op: MDU_mult=0, MDU_multu=1, MDU_div=2, MDU_divu=3, MDU_mfhi=4, MDU_mflo=5, MDU_mthi=6, MDU_mtlo=7.
- start  input  1  E-stage instruction is mult/multu/div/divu (MDU_start).
- mt_en  input  1  E-stage instruction is mthi/mtlo.
- A  input  32  rs operand (forwarded).
- B  input  32  rt operand (forwarded).
- req  input  1  CP0 exception/interrupt flush of the E-stage instruction, this cycle.
- D_mdu_use  input  1  D-stage instruction is md, mt or mf.
- busy  output  1  multi-cycle operation in progress.
- stall  output  1  freeze D and bubble E.
- out  output  32  mfhi/mflo read data.
- HI  output  32  committed HI.
- LO  output  32  committed LO.

Behaviour:
- Reset (asynchronous, active-low): HI=0, LO=0, temp_hi=0, temp_lo=0, cnt=0, state=IDLE, busy=0. out and stall follow from those values.
- States:
  - IDLE: busy=0.
  - BUSY: busy=1, cnt holds the remaining cycles.
- IDLE, start=1, req=0 at an edge:
  - compute temp_hi/temp_lo from A, B.
  - cnt <= MULT_CYCLES for op 0/1; cnt <= DIV_CYCLES for op 2/3.
  - go BUSY.
- IDLE, start=1, req=1: ignored. No state change, HI/LO unchanged.
- BUSY at each edge:
  - if cnt==1: HI<=temp_hi, LO<=temp_lo, cnt<=0, go IDLE.
  - else: cnt<=cnt-1.
  - busy is high for exactly N consecutive cycles after the start edge. HI/LO become visible on the edge that drops busy.
- start while BUSY: ignored. The pipeline guarantees this cannot happen, because stall holds the instruction in D.
- req while BUSY: no effect. The in-flight op belongs to an already-committed instruction and must complete.
- Reset mid-operation: aborts immediately. HI/LO clear to 0; the pending result is discarded.
- mthi/mtlo (mt_en=1, req=0, state IDLE):
  - HI<=A or LO<=A at the edge.
  - mt_en with req=1: no write.
  - mt_en while BUSY: ignored, since stall keeps it out of E.
- out:
  - combinational: MDUOp==MDU_mfhi ? HI : MDUOp==MDU_mflo ? LO : 0.
  - reflects committed values only, never temp_*.
- stall = D_mdu_use & (start | busy).
  - start is included so a back-to-back md/mf pair stalls from the very first cycle.
  - Not gated by req; CP0 flush takes priority in the pipeline.
- Arithmetic:
  - mult: {HI,LO} = signed(A) * signed(B), 64-bit.
  - multu: the same, unsigned.
  - div: LO = quotient truncated toward zero; HI = remainder carrying the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - divu: unsigned LO = quotient, HI = remainder.
- Divide by zero (div/divu, B==0): full DIV_CYCLES busy period; at commit HI and LO keep their prior values.

Decomposition:
- def.v additions:
  - MDU_* op encodings (3-bit) as listed.
  - MDU_IDLE / MDU_BUSY state codes.
  - defaults for MULT_CYCLES / DIV_CYCLES.
- One combinational sub-module, mdu_arith:
  - inputs: op, A, B.
  - outputs: res_hi, res_lo, div0 flag.
- mdu_ctrl holds the FSM, counter, temp/HI/LO registers and stall logic.

Test Plan:
- mult, A=0xFFFFFFFE (-2), B=3 → busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. mflo afterwards gives out=0xFFFFFFFA.
- divu A=7, B=2, then div A=0xFFFFFFF9 (-7), B=2:
  - divu: busy for 10 cycles, then LO=3, HI=1.
  - div: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div with B=0 after mtlo 0x1234 / mthi 0x5678 → busy for 10 cycles; LO=0x1234 and HI=0x5678 unchanged.
- mult start with req=1 → busy stays 0 and HI/LO unchanged. mtlo A=0xAA with req=1 → LO unchanged.
- D_mdu_use=1 in the start cycle and during busy → stall=1 on each of those 6 cycles (start + 5 busy). stall=0 on the cycle after busy falls.
- reset low on the 3rd busy cycle of a mult → busy, cnt, HI and LO read 0 immediately, with no clock edge needed. After release, a new multu 0xFFFFFFFF×2 gives HI=1, LO=0xFFFFFFFE.
